// File: rtl/dm8_scan_le_if.sv
// ---------------------------------------------------------------------------
// dm8_scan_le_if
//   Bundles the data, control and status signals of the dm8_scan_le
//   registered 1-to-8 demultiplexer.
//
//   Signals
//     in       data bit to be distributed
//     sel[2:0] manual-mode destination index
//     e        enable (freezes writes, strobes and scan counters when low)
//     load     manual write request (honoured only in IDLE)
//     scan_en  level, high selects auto-scan mode
//     clr      synchronous clear of o
//     o[7:0]   latched demux outputs
//     strobe   one-hot active destination
//     idx[2:0] current scan index (0 in IDLE)
//     wr_ack   one-cycle pulse when o first shows a newly written bit
//     frame    one-cycle pulse coincident with the slot-7 scan write
//
//   Modports
//     master   side that drives data/control and observes status
//     slave    the demultiplexer itself
// ---------------------------------------------------------------------------
interface dm8_scan_le_if;
    logic       in;
    logic [2:0] sel;
    logic       e;
    logic       load;
    logic       scan_en;
    logic       clr;
    logic [7:0] o;
    logic [7:0] strobe;
    logic [2:0] idx;
    logic       wr_ack;
    logic       frame;

    modport master (
        output in, sel, e, load, scan_en, clr,
        input  o, strobe, idx, wr_ack, frame
    );

    modport slave (
        input  in, sel, e, load, scan_en, clr,
        output o, strobe, idx, wr_ack, frame
    );
endinterface

// File: rtl/dm8_scan_le.sv
// ---------------------------------------------------------------------------
// dm8_scan_le
//   Registered 1-to-8 demultiplexer with enable. A single serial bit is
//   latched into one of eight output bits, either at a caller-chosen index
//   (manual mode, IDLE) or at an index walked by an internal slot counter
//   that advances every DIV clocks (auto-scan mode, SCAN).
//
//   Parameters
//     DIV      clock cycles per scan slot, 1..255
//
//   Ports
//     clk      system clock, rising edge
//     rst      asynchronous, active-high reset
//     bus      dm8_scan_le_if.slave (data, control and status signals)
// ---------------------------------------------------------------------------
module dm8_scan_le #(
    parameter int DIV = 4
) (
    input  logic           clk,
    input  logic           rst,
    dm8_scan_le_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DIV - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] cnt;
    logic [2:0] idx_q;
    logic [7:0] o_q;
    logic       wr_ack_q;
    logic       frame_q;
    logic [7:0] strobe_c;

    // Write qualification. A mode change on this edge (scan_en disagreeing
    // with the current state) always suppresses the write.
    logic       slot_done;
    logic       manual_wr;
    logic       do_write;
    logic [2:0] wr_idx;

    assign slot_done = (state == SCAN) && bus.scan_en && bus.e && (cnt == CNT_LAST);
    assign manual_wr = (state == IDLE) && !bus.scan_en && bus.e && bus.load;
    // clr wins over any simultaneous write; the counters still advance.
    assign do_write  = (slot_done || manual_wr) && !bus.clr;
    assign wr_idx    = (state == SCAN) ? idx_q : bus.sel;

    // ---------------- state register ----------------
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.scan_en)  next_state = SCAN;
            SCAN: if (!bus.scan_en) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        strobe_c = 8'h00;
        if (bus.e) begin
            strobe_c = (state == SCAN) ? (8'h01 << idx_q) : (8'h01 << bus.sel);
        end
    end

    // ---------------- datapath: counters, outputs, pulses ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 8'h00;
            idx_q    <= 3'd0;
            o_q      <= 8'h00;
            wr_ack_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            if (bus.clr) begin
                o_q <= 8'h00;
            end else if (do_write) begin
                o_q[wr_idx] <= bus.in;
            end

            wr_ack_q <= do_write;
            frame_q  <= slot_done && !bus.clr && (idx_q == 3'd7);

            case (state)
                IDLE: begin
                    // Entry into SCAN (or staying idle) starts from slot 0.
                    cnt   <= 8'h00;
                    idx_q <= 3'd0;
                end
                SCAN: begin
                    if (!bus.scan_en) begin
                        cnt   <= 8'h00;
                        idx_q <= 3'd0;
                    end else if (bus.e) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= 8'h00;
                            idx_q <= idx_q + 3'd1;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    // e low: cnt and idx hold so the slot resumes where it stopped.
                end
                default: begin
                    cnt   <= 8'h00;
                    idx_q <= 3'd0;
                end
            endcase
        end
    end

    assign bus.o      = o_q;
    assign bus.strobe = strobe_c;
    assign bus.idx    = idx_q;
    assign bus.wr_ack = wr_ack_q;
    assign bus.frame  = frame_q;

endmodule

// File: tb/tb_dm8_scan_le.sv
// ---------------------------------------------------------------------------
// tb_dm8_scan_le
//   Directed self-checking bench for dm8_scan_le with DIV=4. Inputs change
//   1 time unit after each rising edge; outputs are observed at that point.
// ---------------------------------------------------------------------------
module tb_dm8_scan_le;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dm8_scan_le_if bus ();

    dm8_scan_le #(.DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] onehot(input logic [2:0] i);
        logic [7:0] v;
        v = 8'h00;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        bus.in = 1'b0; bus.sel = 3'd0; bus.e = 1'b0; bus.load = 1'b0;
        bus.scan_en = 1'b0; bus.clr = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.o !== 8'h00) begin errors++; $display("FAIL reset_o got=%h exp=00", bus.o); end
        checks++; if (bus.idx !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", bus.idx); end
        checks++; if (bus.strobe !== 8'h00) begin errors++; $display("FAIL reset_strobe got=%h exp=00", bus.strobe); end
        checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL reset_wr_ack got=%b exp=0", bus.wr_ack); end
        checks++; if (bus.frame !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b exp=0", bus.frame); end
    endtask

    task automatic test_manual();
        bus.e = 1'b1; bus.sel = 3'd5; bus.in = 1'b1; bus.load = 1'b1;
        #1;
        checks++; if (bus.strobe !== 8'h20) begin errors++; $display("FAIL man_strobe got=%h exp=20", bus.strobe); end
        checks++; if (bus.o !== 8'h00) begin errors++; $display("FAIL man_latency got=%h exp=00", bus.o); end
        tick();
        bus.load = 1'b0;
        checks++; if (bus.o !== 8'h20) begin errors++; $display("FAIL man_write5 got=%h exp=20", bus.o); end
        checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL man_ack got=%b exp=1", bus.wr_ack); end
        tick();
        checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL man_ack_pulse got=%b exp=0", bus.wr_ack); end
        // Write 0 back into bit 5.
        bus.in = 1'b0; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        checks++; if (bus.o !== 8'h00) begin errors++; $display("FAIL man_write0 got=%h exp=00", bus.o); end
        // Set bit 1, then try to overwrite it with e low.
        bus.sel = 3'd1; bus.in = 1'b1; bus.load = 1'b1;
        tick();
        checks++; if (bus.o !== 8'h02) begin errors++; $display("FAIL man_write1 got=%h exp=02", bus.o); end
        bus.e = 1'b0; bus.in = 1'b0;
        #1;
        checks++; if (bus.strobe !== 8'h00) begin errors++; $display("FAIL man_strobe_off got=%h exp=00", bus.strobe); end
        tick();
        checks++; if (bus.o !== 8'h02) begin errors++; $display("FAIL man_e0_hold got=%h exp=02", bus.o); end
        checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL man_e0_ack got=%b exp=0", bus.wr_ack); end
        bus.load = 1'b0; bus.e = 1'b1;
    endtask

    task automatic test_back_to_back();
        bus.load = 1'b1; bus.sel = 3'd0; bus.in = 1'b1;
        tick();
        checks++; if (bus.o !== 8'h03) begin errors++; $display("FAIL b2b_first got=%h exp=03", bus.o); end
        checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got=%b exp=1", bus.wr_ack); end
        bus.sel = 3'd7;
        tick();
        checks++; if (bus.o !== 8'h83) begin errors++; $display("FAIL b2b_second got=%h exp=83", bus.o); end
        checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2 got=%b exp=1", bus.wr_ack); end
        bus.load = 1'b0;
        tick();
        checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_end got=%b exp=0", bus.wr_ack); end
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        checks++; if (bus.o !== 8'h00) begin errors++; $display("FAIL b2b_clr got=%h exp=00", bus.o); end
    endtask

    task automatic test_scan();
        logic [8:0] exp_o;
        bus.e = 1'b1; bus.in = 1'b1; bus.load = 1'b1; bus.sel = 3'd4; bus.scan_en = 1'b1;
        tick();  // entry edge: no manual write despite load
        bus.load = 1'b0;
        checks++; if (bus.o !== 8'h00) begin errors++; $display("FAIL scan_entry_nowrite got=%h exp=00", bus.o); end
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++; if (bus.wr_ack !== 1'b0 || bus.idx !== 3'(k) || bus.strobe !== onehot(3'(k))) begin
                    errors++;
                    $display("FAIL scan_wait slot=%0d ack=%b idx=%0d strobe=%h exp ack=0 idx=%0d strobe=%h",
                             k, bus.wr_ack, bus.idx, bus.strobe, k, onehot(3'(k)));
                end
            end
            tick();
            exp_o = (9'd1 << (k + 1)) - 9'd1;
            checks++; if (bus.o !== exp_o[7:0] || bus.wr_ack !== 1'b1) begin
                errors++;
                $display("FAIL scan_write slot=%0d o=%h ack=%b exp o=%h ack=1", k, bus.o, bus.wr_ack, exp_o[7:0]);
            end
            checks++; if (bus.frame !== (k == 7) || bus.idx !== 3'((k + 1) % 8)) begin
                errors++;
                $display("FAIL scan_frame_idx slot=%0d frame=%b idx=%0d exp frame=%b idx=%0d",
                         k, bus.frame, bus.idx, (k == 7), (k + 1) % 8);
            end
        end
        tick();
        checks++; if (bus.frame !== 1'b0 || bus.wr_ack !== 1'b0 || bus.o !== 8'hFF) begin
            errors++;
            $display("FAIL scan_after_frame frame=%b ack=%b o=%h exp 0 0 ff", bus.frame, bus.wr_ack, bus.o);
        end
    endtask

    task automatic test_freeze();
        // Leave SCAN, clear, and re-enter so the slot position is known.
        bus.scan_en = 1'b0;
        tick();
        checks++; if (bus.idx !== 3'd0 || bus.o !== 8'hFF) begin
            errors++; $display("FAIL frz_abort idx=%0d o=%h exp 0 ff", bus.idx, bus.o);
        end
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0; bus.scan_en = 1'b1;
        tick();
        repeat (14) tick();  // idx=3, cnt=2
        checks++; if (bus.idx !== 3'd3 || bus.o !== 8'h07) begin
            errors++; $display("FAIL frz_pos idx=%0d o=%h exp 3 07", bus.idx, bus.o);
        end
        bus.e = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.idx !== 3'd3 || bus.o !== 8'h07 || bus.strobe !== 8'h00 || bus.wr_ack !== 1'b0) begin
                errors++;
                $display("FAIL frz_hold cyc=%0d idx=%0d o=%h strobe=%h ack=%b exp 3 07 00 0",
                         i, bus.idx, bus.o, bus.strobe, bus.wr_ack);
            end
        end
        bus.e = 1'b1;
        tick();
        checks++; if (bus.o !== 8'h07 || bus.wr_ack !== 1'b0) begin
            errors++; $display("FAIL frz_resume1 o=%h ack=%b exp 07 0", bus.o, bus.wr_ack);
        end
        tick();
        checks++; if (bus.o !== 8'h0F || bus.wr_ack !== 1'b1 || bus.idx !== 3'd4) begin
            errors++; $display("FAIL frz_resume2 o=%h ack=%b idx=%0d exp 0f 1 4", bus.o, bus.wr_ack, bus.idx);
        end
    endtask

    task automatic test_abort_clear();
        repeat (8) tick();  // slots 4 and 5 written, now idx=6, cnt=0
        checks++; if (bus.idx !== 3'd6 || bus.o !== 8'h3F) begin
            errors++; $display("FAIL abort_pos idx=%0d o=%h exp 6 3f", bus.idx, bus.o);
        end
        bus.scan_en = 1'b0; bus.sel = 3'd2;
        tick();
        checks++; if (bus.idx !== 3'd0 || bus.o !== 8'h3F || bus.strobe !== 8'h04) begin
            errors++; $display("FAIL abort_idle idx=%0d o=%h strobe=%h exp 0 3f 04", bus.idx, bus.o, bus.strobe);
        end
        tick();
        checks++; if (bus.o !== 8'h3F || bus.wr_ack !== 1'b0) begin
            errors++; $display("FAIL abort_retain o=%h ack=%b exp 3f 0", bus.o, bus.wr_ack);
        end
        bus.clr = 1'b1; bus.load = 1'b1; bus.in = 1'b1;
        tick();
        bus.clr = 1'b0; bus.load = 1'b0;
        checks++; if (bus.o !== 8'h00 || bus.wr_ack !== 1'b0) begin
            errors++; $display("FAIL clr_priority o=%h ack=%b exp 00 0", bus.o, bus.wr_ack);
        end
    endtask

    task automatic test_async_reset();
        bus.scan_en = 1'b1; bus.in = 1'b1;
        tick();
        repeat (5) tick();  // slot 0 written, idx=1
        checks++; if (bus.o !== 8'h01 || bus.idx !== 3'd1) begin
            errors++; $display("FAIL arst_pre o=%h idx=%0d exp 01 1", bus.o, bus.idx);
        end
        #2;
        rst = 1'b1;
        #1;  // still well before the next rising edge
        checks++; if (bus.o !== 8'h00 || bus.idx !== 3'd0 || bus.wr_ack !== 1'b0 || bus.frame !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate o=%h idx=%0d ack=%b frame=%b exp 00 0 0 0",
                     bus.o, bus.idx, bus.wr_ack, bus.frame);
        end
        bus.scan_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.o !== 8'h00 || bus.idx !== 3'd0) begin
            errors++; $display("FAIL arst_release o=%h idx=%0d exp 00 0", bus.o, bus.idx);
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_back_to_back();
        test_scan();
        test_freeze();
        test_abort_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm8_scan_le.md
Name: dm8_scan_le

Overview:
- Registered 1-to-8 demultiplexer with enable; the distribution-side counterpart of the 8:1 select-with-enable mux used in the game datapath.
- Routes a single serial bit into one of eight latched output bits (per-player flags, LED or anode lines).
- Two modes:
  - Manual: the caller supplies the select value.
  - Auto-scan: an internal slot counter walks indices 0..7 at a programmable rate and produces one-hot strobes.

Parameters:
- DIV, 4: clock cycles per scan slot; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in  in  1  data bit to be distributed.
- sel  in  3  destination index in manual mode.
- e  in  1  enable. When low: no writes, strobes forced to 0, scan counters frozen.
- load  in  1  manual write request; sampled only in IDLE.
- scan_en  in  1  level; high selects auto-scan mode.
- clr  in  1  synchronous clear of o.
- o  out  8  latched demux outputs.
- strobe  out  8  one-hot index of the active destination (combinational from state, idx/sel and e).
- idx  out  3  current scan index; 0 in IDLE.
- wr_ack  out  1  one-cycle pulse, high in the cycle o first shows a newly written bit.
- frame  out  1  one-cycle pulse coincident with the write of slot 7.

Behaviour:
- Reset (asynchronous, rst=1): o=8'h00, state=IDLE, idx=0, cnt=0, wr_ack=0, frame=0. strobe follows its combinational rule, i.e. onehot(sel) if e=1.
- States: IDLE and SCAN. Internal cnt is 8 bits, counting 0..DIV-1.
- IDLE:
  - strobe = e ? onehot(sel) : 8'h00.
  - Edge with e=1, load=1, clr=0: o[sel] <= in and wr_ack <= 1. Other bits of o are unchanged.
  - Write latency: o is updated 1 cycle after the sampling edge.
  - Back-to-back loads are legal: one write per cycle, wr_ack stays high continuously.
  - load with e=0: ignored, wr_ack <= 0.
- IDLE -> SCAN on an edge where scan_en=1: cnt<=0, idx<=0. No manual write occurs on that edge, even if load=1.
- SCAN:
  - strobe = e ? onehot(idx) : 8'h00. load is ignored.
  - Each edge with e=1: if cnt==DIV-1 then o[idx] <= in, wr_ack <= 1, cnt <= 0, idx <= idx+1 (wraps 7->0); additionally frame <= 1 when idx==7. Otherwise cnt <= cnt+1, wr_ack <= 0, frame <= 0.
  - The first write occurs DIV cycles after entry. A full frame is 8*DIV cycles.
  - DIV=1: a write every cycle, with wr_ack held high.
  - e=0: cnt and idx hold, no write, wr_ack=0, frame=0. Resuming e=1 continues the same slot from the held cnt.
- SCAN -> IDLE on an edge where scan_en=0 (abort, any cnt): cnt<=0, idx<=0, no write on that edge. Already-written o bits are retained.
- clr=1: o <= 8'h00 on that edge.
  - clr has priority over any simultaneous write: the write is dropped, wr_ack <= 0, frame <= 0.
  - State, cnt and idx advance as if the write had occurred.
- wr_ack and frame are registered pulses. Neither is ever high for more than one cycle per write.
- Reset asserted mid-scan or mid-write returns everything to the reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset: rst=1 for 3 cycles then release, with e=0 -> o=00, idx=0, strobe=00, wr_ack=0.
- Manual write: IDLE, e=1, sel=5, in=1, load=1 for 1 cycle.
  - Next cycle: o=8'h20 and wr_ack=1 for 1 cycle. strobe=8'h20 while sel=5.
  - Then sel=5, in=0, load=1 -> o=00.
  - load with e=0 -> o unchanged, wr_ack=0.
- Auto-scan, DIV=4: e=1, in=1, scan_en=1.
  - wr_ack pulses every 4 cycles; o fills 01, 03, 07 ... FF in order.
  - frame pulses once with the slot-7 write (32 cycles after entry); idx wraps to 0.
- Freeze: during SCAN at idx=3, cnt=2, drop e for 5 cycles.
  - While e=0: idx and o hold, strobe=00.
  - After e returns high: the idx 3 write happens exactly 2 cycles later.
- Abort and clear:
  - scan_en low at idx=6 -> IDLE next cycle, idx=0, o retains bits 0..5.
  - clr=1 together with load (sel=2, in=1) -> o=00, wr_ack=0.
- Async reset mid-scan: rst pulses between clock edges -> o=00 and idx=0 immediately, before the next edge.
